// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone arbiter (master_* in, slave_* out, grant one-hot, timeout_evt watchdog pulse)
module wb_rr_arbiter #(
  parameter int MASTER_COUNT = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int TAG_WIDTH    = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                                 sys_clk,
  input  logic                                 sys_rst,
  input  logic [MASTER_COUNT-1:0]              master_cyc,
  input  logic [MASTER_COUNT-1:0]              master_stb,
  input  logic [MASTER_COUNT-1:0]              master_we,
  input  logic [MASTER_COUNT*TAG_WIDTH-1:0]    master_tag,
  input  logic [MASTER_COUNT*DATA_WIDTH/8-1:0] master_sel,
  input  logic [MASTER_COUNT*ADDR_WIDTH-1:0]   master_adr,
  input  logic [MASTER_COUNT*DATA_WIDTH-1:0]   master_mosi,
  output logic [MASTER_COUNT*DATA_WIDTH-1:0]   master_miso,
  output logic [MASTER_COUNT-1:0]              master_ack,
  output logic [MASTER_COUNT-1:0]              master_err,
  output logic                                 slave_cyc,
  output logic                                 slave_stb,
  output logic                                 slave_we,
  output logic [TAG_WIDTH-1:0]                 slave_tag,
  output logic [DATA_WIDTH/8-1:0]              slave_sel,
  output logic [ADDR_WIDTH-1:0]                slave_adr,
  output logic [DATA_WIDTH-1:0]                slave_mosi,
  input  logic [DATA_WIDTH-1:0]                slave_miso,
  input  logic                                 slave_ack,
  input  logic                                 slave_err,
  output logic [MASTER_COUNT-1:0]              grant,
  output logic                                 timeout_evt
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = $clog2(MASTER_COUNT);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0] state;
  logic [IW-1:0] gidx, last, win, j;
  logic [CW-1:0] cnt;
  logic found, busy, fire;
  assign busy = state == BUSY;
  assign fire = TIMEOUT > 0 && busy && cnt == CW'(TIMEOUT);
  // first requester after the previous owner, wrapping modulo MASTER_COUNT
  always_comb begin
    found = 1'b0;
    win = last;
    j = last;
    for (int k = 1; k <= MASTER_COUNT; k++) begin
      j = IW'((int'(last) + k) % MASTER_COUNT);
      if (!found && master_cyc[j]) begin
        found = 1'b1;
        win = j;
      end
    end
  end
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state <= IDLE;
      gidx <= '0;
      last <= IW'(MASTER_COUNT - 1);
      cnt <= '0;
    end else if (!busy) begin
      if (found) begin
        state <= BUSY;
        gidx <= win;
        last <= win;
      end
      cnt <= '0;
    end else if (!master_cyc[gidx]) begin
      state <= IDLE;
      cnt <= '0;
    end else
      cnt <= (fire || slave_ack || slave_err) ? '0 : (TIMEOUT > 0 && master_stb[gidx]) ? cnt + 1'b1 : cnt;
  assign grant       = {{(MASTER_COUNT-1){1'b0}}, busy} << gidx;
  assign master_ack  = {{(MASTER_COUNT-1){1'b0}}, busy & slave_ack & !fire} << gidx;
  assign master_err  = {{(MASTER_COUNT-1){1'b0}}, busy & (slave_err | fire)} << gidx;
  assign master_miso = {MASTER_COUNT{slave_miso}};
  assign slave_cyc   = busy & master_cyc[gidx];
  assign slave_stb   = busy & master_stb[gidx] & !fire;
  assign slave_we    = busy & master_we[gidx];
  assign slave_tag   = busy ? master_tag[gidx*TAG_WIDTH +: TAG_WIDTH] : '0;
  assign slave_sel   = busy ? master_sel[gidx*SW +: SW] : '0;
  assign slave_adr   = busy ? master_adr[gidx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign slave_mosi  = busy ? master_mosi[gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign timeout_evt = fire;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed vector bench for wb_rr_arbiter
module tb_wb_rr_arbiter;
  localparam int MC = 2, DW = 32, AW = 32, TW = 4, TO = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [MC-1:0] m_cyc, m_stb, m_we, m_ack, m_err, grant;
  logic [MC*TW-1:0] m_tag;
  logic [MC*DW/8-1:0] m_sel;
  logic [MC*AW-1:0] m_adr;
  logic [MC*DW-1:0] m_mosi, m_miso;
  logic s_cyc, s_stb, s_we, s_ack, s_err, evt;
  logic [TW-1:0] s_tag;
  logic [DW/8-1:0] s_sel;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_mosi, s_miso;
  int passed = 0, total = 0;
  typedef struct packed {
    logic [1:0] cyc;
    logic sack;
    logic [1:0] grant;
    logic scyc;
    logic [1:0] ack;
  } vec_t;
  vec_t tbl [20];
  wb_rr_arbiter #(.MASTER_COUNT(MC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .TIMEOUT(TO)) dut (
    .sys_clk(clk), .sys_rst(rst),
    .master_cyc(m_cyc), .master_stb(m_stb), .master_we(m_we), .master_tag(m_tag),
    .master_sel(m_sel), .master_adr(m_adr), .master_mosi(m_mosi), .master_miso(m_miso),
    .master_ack(m_ack), .master_err(m_err),
    .slave_cyc(s_cyc), .slave_stb(s_stb), .slave_we(s_we), .slave_tag(s_tag),
    .slave_sel(s_sel), .slave_adr(s_adr), .slave_mosi(s_mosi), .slave_miso(s_miso),
    .slave_ack(s_ack), .slave_err(s_err), .grant(grant), .timeout_evt(evt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic step(input logic [1:0] c, input logic a);
    @(posedge clk);
    #1;
    m_cyc = c;
    m_stb = c;
    s_ack = a;
    s_miso = $urandom;
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0; s_err = 1'b0; s_miso = '0;
    m_tag = 8'h21; m_sel = 8'h3f; m_adr = {32'h8000, 32'h4000}; m_mosi = {32'hbbbb, 32'haaaa};
    tbl = '{
      '{2'b11, 1'b0, 2'b00, 1'b0, 2'b00},
      '{2'b11, 1'b1, 2'b01, 1'b1, 2'b01},
      '{2'b10, 1'b0, 2'b01, 1'b0, 2'b00},
      '{2'b11, 1'b0, 2'b00, 1'b0, 2'b00},
      '{2'b11, 1'b1, 2'b10, 1'b1, 2'b10},
      '{2'b01, 1'b0, 2'b10, 1'b0, 2'b00},
      '{2'b11, 1'b0, 2'b00, 1'b0, 2'b00},
      '{2'b11, 1'b1, 2'b01, 1'b1, 2'b01},
      '{2'b10, 1'b0, 2'b01, 1'b0, 2'b00},
      '{2'b11, 1'b0, 2'b00, 1'b0, 2'b00},
      '{2'b11, 1'b1, 2'b10, 1'b1, 2'b10},
      '{2'b11, 1'b1, 2'b10, 1'b1, 2'b10},
      '{2'b11, 1'b1, 2'b10, 1'b1, 2'b10},
      '{2'b11, 1'b1, 2'b10, 1'b1, 2'b10},
      '{2'b01, 1'b0, 2'b10, 1'b0, 2'b00},
      '{2'b01, 1'b0, 2'b00, 1'b0, 2'b00},
      '{2'b01, 1'b0, 2'b01, 1'b1, 2'b00},
      '{2'b01, 1'b1, 2'b01, 1'b1, 2'b01},
      '{2'b00, 1'b0, 2'b01, 1'b0, 2'b00},
      '{2'b00, 1'b0, 2'b00, 1'b0, 2'b00}
    };
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_scyc", {s_cyc, s_stb, s_we}, 0);
    chk("rst_adr", s_adr, 0);
    chk("rst_ack_err", {m_ack, m_err}, 0);
    chk("rst_evt", evt, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].cyc, tbl[i].sack);
      chk($sformatf("row%0d_grant", i), grant, tbl[i].grant);
      chk($sformatf("row%0d_scyc", i), s_cyc, tbl[i].scyc);
      chk($sformatf("row%0d_sstb", i), s_stb, tbl[i].scyc);
      chk($sformatf("row%0d_ack", i), m_ack, tbl[i].ack);
      chk($sformatf("row%0d_err", i), {m_err, evt}, 0);
      chk($sformatf("row%0d_adr", i), s_adr, tbl[i].grant == 2'b01 ? 64'h4000 : tbl[i].grant == 2'b10 ? 64'h8000 : 64'h0);
      chk($sformatf("row%0d_miso", i), {m_miso[63:32] ^ s_miso, m_miso[31:0] ^ s_miso}, 0);
    end
    step(2'b10, 1'b0);
    chk("wd_idle_grant", grant, 0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < TO; i++) begin
        step(2'b10, 1'b0);
        chk($sformatf("wd%0d_stall%0d_err", r, i), {m_err, evt}, 0);
        chk($sformatf("wd%0d_stall%0d_stb", r, i), s_stb, 1);
        chk($sformatf("wd%0d_stall%0d_grant", r, i), grant, 2'b10);
      end
      step(2'b10, r[0]);
      chk($sformatf("wd%0d_fire_err", r), m_err, 2'b10);
      chk($sformatf("wd%0d_fire_evt", r), evt, 1);
      chk($sformatf("wd%0d_fire_stb", r), {s_cyc, s_stb}, 2'b10);
      chk($sformatf("wd%0d_fire_ack", r), m_ack, 0);
      chk($sformatf("wd%0d_fire_grant", r), grant, 2'b10);
    end
    step(2'b00, 1'b0);
    chk("wd_after_term", {m_ack, m_err, evt}, 0);
    chk("wd_after_grant", grant, 2'b10);
    step(2'b00, 1'b0);
    chk("wd_release_grant", grant, 0);
    m_we = 2'b01;
    step(2'b01, 1'b0);
    chk("ar_idle_grant", grant, 0);
    step(2'b01, 1'b1);
    chk("ar_busy_grant", grant, 2'b01);
    chk("ar_busy_we", {s_cyc, s_we}, 2'b11);
    chk("ar_busy_ack", m_ack, 2'b01);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_grant", grant, 0);
    chk("ar_slave_ctl", {s_cyc, s_stb, s_we}, 0);
    chk("ar_slave_bus", {s_adr, s_sel, s_tag}, 0);
    chk("ar_ack_err", {m_ack, m_err, evt}, 0);
    m_cyc = 2'b11; m_stb = 2'b11; m_we = '0; s_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(2'b11, 1'b0);
    chk("ar_prio_grant", grant, 2'b01);
    chk("ar_prio_adr", s_adr, 64'h4000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
